// File: rtl/seg_word_sched.sv
// Round-robin scheduler that picks one of NUM_SRC segment words for a display,
// with a preemptive alert slot. Define SEG_SCHED_BLANK_EN to insert a blank GAP
// between different sources.
module seg_word_sched #(
  parameter int SEG_UNITS    = 4,
  parameter int NUM_SRC      = 4,
  parameter int DWELL_CYCLES = 50000000,
  parameter int BLANK_CYCLES = 5000000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_SRC*8*SEG_UNITS-1:0] src_word,
  input  logic [NUM_SRC-1:0]           src_valid,
  input  logic                         alert_req,
  input  logic [8*SEG_UNITS-1:0]       alert_word,
  output logic                         alert_ack,
  output logic [8*SEG_UNITS-1:0]       word,
  output logic [2:0]                   cur_src,
  output logic                         alert_active
);

  localparam int W = 8 * SEG_UNITS;

`ifdef SEG_SCHED_BLANK_EN
  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
`else
  localparam int CNT_MAX = DWELL_CYCLES;
`endif
  localparam int CW = $clog2(CNT_MAX) + 1;

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
`ifdef SEG_SCHED_BLANK_EN
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
`endif

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHOW  = 2'd1;
  localparam logic [1:0] ST_ALERT = 2'd2;
`ifdef SEG_SCHED_BLANK_EN
  localparam logic [1:0] ST_GAP   = 2'd3;
`endif

  // Parameter legality is enforced at elaboration.
  if (NUM_SRC < 1 || NUM_SRC > 8) begin : g_bad_num_src
    $error("seg_word_sched: NUM_SRC must be 1..8");
  end
  if (DWELL_CYCLES < 2) begin : g_bad_dwell
    $error("seg_word_sched: DWELL_CYCLES must be >= 2");
  end
  if (BLANK_CYCLES < 1) begin : g_bad_blank
    $error("seg_word_sched: BLANK_CYCLES must be >= 1");
  end

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  function automatic logic [2:0] wrap_inc(input logic [2:0] idx);
    return (int'(idx) >= NUM_SRC - 1) ? 3'd0 : idx + 3'd1;
  endfunction

  // Lowest valid index at or after start, wrapping modulo NUM_SRC.
  function automatic pick_t find_from(input logic [NUM_SRC-1:0] valid,
                                      input logic [2:0]         start);
    pick_t hit;
    int    idx;
    hit = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = int'(start) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      for (int j = 0; j < NUM_SRC; j++) begin
        if (j == idx && valid[j]) hit = '{found: 1'b1, idx: 3'(j)};
      end
    end
    return hit;
  endfunction

  function automatic logic valid_at(input logic [NUM_SRC-1:0] valid,
                                    input logic [2:0]         sel);
    logic v;
    v = 1'b0;
    for (int j = 0; j < NUM_SRC; j++) begin
      if (3'(j) == sel) v = valid[j];
    end
    return v;
  endfunction

  function automatic logic [W-1:0] word_at(input logic [NUM_SRC*W-1:0] words,
                                           input logic [2:0]           sel);
    logic [W-1:0] w;
    w = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      if (3'(j) == sel) w = words[j*W +: W];
    end
    return w;
  endfunction

  logic [1:0]    state_q,      state_d;
  logic [2:0]    cur_src_q,    cur_src_d;
  logic [2:0]    saved_q,      saved_d;
  logic [2:0]    ptr_q,        ptr_d;
  logic [CW-1:0] cnt_q,        cnt_d;
  logic [W-1:0]  alert_word_q, alert_word_d;
  logic [W-1:0]  word_q,       word_d;
  logic          ack_q,        ack_d;

  pick_t next_pick;
  pick_t ptr_pick;
  pick_t resume_pick;
  logic  cur_valid;
  logic  accept;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    cur_src_d    = cur_src_q;
    saved_d      = saved_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    alert_word_d = alert_word_q;
    word_d       = '0;
    ack_d        = 1'b0;
    accept       = 1'b0;

    next_pick   = find_from(src_valid, wrap_inc(cur_src_q));
    ptr_pick    = find_from(src_valid, ptr_q);
    resume_pick = find_from(src_valid, wrap_inc(saved_q));
    cur_valid   = valid_at(src_valid, cur_src_q);

    case (state_q)
      ST_IDLE: begin
        if (alert_req) begin
          accept = 1'b1;
        end else if (ptr_pick.found) begin
          state_d   = ST_SHOW;
          cur_src_d = ptr_pick.idx;
          cnt_d     = '0;
        end
      end

      ST_SHOW: begin
        // Alert acceptance preempts any rotation step decided this cycle.
        if (alert_req) begin
          accept = 1'b1;
        end else if (!cur_valid || cnt_q == DWELL_LAST) begin
          cnt_d = '0;
          if (!next_pick.found) begin
            state_d = ST_IDLE;
          end else if (next_pick.idx != cur_src_q) begin
            cur_src_d = next_pick.idx;
`ifdef SEG_SCHED_BLANK_EN
            state_d   = ST_GAP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_ALERT: begin
        if (cnt_q == DWELL_LAST) begin
          cnt_d = '0;
          if (valid_at(src_valid, saved_q)) begin
            state_d   = ST_SHOW;
            cur_src_d = saved_q;
          end else if (resume_pick.found) begin
            state_d   = ST_SHOW;
            cur_src_d = resume_pick.idx;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

`ifdef SEG_SCHED_BLANK_EN
      ST_GAP: begin
        // cur_src already holds the target; re-check it when the gap ends.
        if (alert_req) begin
          accept = 1'b1;
        end else if (cnt_q == BLANK_LAST) begin
          cnt_d = '0;
          if (cur_valid) begin
            state_d = ST_SHOW;
          end else if (next_pick.found) begin
            state_d   = ST_SHOW;
            cur_src_d = next_pick.idx;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      state_d      = ST_ALERT;
      saved_d      = cur_src_q;
      alert_word_d = alert_word;
      ack_d        = 1'b1;
      cnt_d        = '0;
      cur_src_d    = cur_src_q;
    end

    if (state_d == ST_SHOW) begin
      ptr_d  = wrap_inc(cur_src_d);
      word_d = word_at(src_word, cur_src_d);
    end else if (state_d == ST_ALERT) begin
      word_d = alert_word_d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cur_src_q    <= '0;
      saved_q      <= '0;
      ptr_q        <= '0;
      cnt_q        <= '0;
      alert_word_q <= '0;
      word_q       <= '0;
      ack_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_src_q    <= cur_src_d;
      saved_q      <= saved_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      alert_word_q <= alert_word_d;
      word_q       <= word_d;
      ack_q        <= ack_d;
    end
  end

  assign word         = word_q;
  assign cur_src      = cur_src_q;
  assign alert_ack    = ack_q;
  assign alert_active = (state_q == ST_ALERT);

endmodule

// File: tb/tb_seg_word_sched.sv
// Randomized and directed bench for seg_word_sched against a countdown-based
// reference model of the display rotation.
module tb_seg_word_sched;

  localparam int SEG_UNITS = 4;
  localparam int NUM_SRC   = 4;
  localparam int DWELL     = 8;
  localparam int BLANK     = 3;
  localparam int W         = 8 * SEG_UNITS;

  localparam logic [W-1:0] WA = 32'hA1A2A3A4;
  localparam logic [W-1:0] WB = 32'hB1B2B3B4;
  localparam logic [W-1:0] WC = 32'hC1C2C3C4;
  localparam logic [W-1:0] WD = 32'hD1D2D3D4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NUM_SRC*W-1:0] src_word = '0;
  logic [NUM_SRC-1:0]   src_valid = '0;
  logic                 alert_req = 1'b0;
  logic [W-1:0]         alert_word = '0;
  logic                 alert_ack;
  logic [W-1:0]         word;
  logic [2:0]           cur_src;
  logic                 alert_active;

  int total = 0;
  int bad   = 0;
  int acks  = 0;

  seg_word_sched #(
    .SEG_UNITS   (SEG_UNITS),
    .NUM_SRC     (NUM_SRC),
    .DWELL_CYCLES(DWELL),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .src_word    (src_word),
    .src_valid   (src_valid),
    .alert_req   (alert_req),
    .alert_word  (alert_word),
    .alert_ack   (alert_ack),
    .word        (word),
    .cur_src     (cur_src),
    .alert_active(alert_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: mode 0 idle, 1 show, 2 alert, 3 gap; m_left counts the
  // cycles still to be spent in the current phase, including the present one.
  int           m_mode, m_src, m_left, m_saved, m_ptr;
  logic [W-1:0] m_aword, m_word;
  bit           m_ack;

  function automatic int nxt(input int from);
    for (int k = 0; k < NUM_SRC; k++) begin
      if (src_valid[(from + k) % NUM_SRC]) return (from + k) % NUM_SRC;
    end
    return -1;
  endfunction

  task automatic m_start(input int j);
    m_mode = 1; m_src = j; m_left = DWELL; m_ptr = (j + 1) % NUM_SRC;
  endtask

  task automatic m_go(input int j);
`ifdef SEG_SCHED_BLANK_EN
    m_mode = 3; m_src = j; m_left = BLANK;
`else
    m_start(j);
`endif
  endtask

  task automatic m_accept();
    m_mode = 2; m_saved = m_src; m_aword = alert_word; m_ack = 1; m_left = DWELL;
  endtask

  task automatic model_step();
    int j;
    m_ack = 0;
    if (!rst_n) begin
      m_mode = 0; m_src = 0; m_left = 0; m_saved = 0; m_ptr = 0; m_aword = '0;
    end else begin
      case (m_mode)
        0: if (alert_req) m_accept();
           else if (src_valid != 0) m_start(nxt(m_ptr));
        1: if (alert_req) m_accept();
           else if (!src_valid[m_src] || m_left == 1) begin
             j = nxt((m_src + 1) % NUM_SRC);
             if (j < 0) m_mode = 0;
             else if (j == m_src) m_left = DWELL;
             else m_go(j);
           end else m_left--;
        2: if (m_left == 1) begin
             if (src_valid[m_saved]) m_start(m_saved);
             else begin
               j = nxt((m_saved + 1) % NUM_SRC);
               if (j < 0) m_mode = 0; else m_start(j);
             end
           end else m_left--;
        default: if (alert_req) m_accept();
           else if (m_left == 1) begin
             if (src_valid[m_src]) m_start(m_src);
             else begin
               j = nxt((m_src + 1) % NUM_SRC);
               if (j < 0) m_mode = 0; else m_start(j);
             end
           end else m_left--;
      endcase
    end
    m_word = (m_mode == 1) ? src_word[m_src*W +: W] : (m_mode == 2) ? m_aword : '0;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    if (alert_ack === 1'b1) acks++;
    check({tag, ":word"},  64'(word),         64'(m_word));
    check({tag, ":src"},   64'(cur_src),      64'(m_src));
    check({tag, ":alert"}, 64'(alert_active), 64'(m_mode == 2));
    check({tag, ":ack"},   64'(alert_ack),    64'(m_ack));
  endtask

  // Advance until the model shows source src at dwell count cnt (bounded).
  task automatic wait_for(input int src, input int cnt, input string tag);
    int n = 0;
    while (!(m_mode == 1 && m_src == src && DWELL - m_left == cnt) && n < 100) begin
      tick(tag);
      n++;
    end
    check({tag, ":reached"}, 64'(n < 100), 64'(1));
  endtask

  initial begin
    int a0;
    src_word = {WD, WC, WB, WA};
    rst_n = 1'b0;
    tick("reset");
    tick("reset");
    check("reset_word", 64'(word), 64'(0));
    check("reset_src", 64'(cur_src), 64'(0));
    check("reset_alert", 64'(alert_active), 64'(0));

    // Rotation over sources 0 and 2.
    rst_n = 1'b1;
    src_valid = 4'b0101;
    for (int k = 1; k <= 17; k++) begin
      tick("rot");
      if (k == 8)  check("rot_a_end", 64'(word), 64'(WA));
      if (k == 9)  check("rot_c_start", 64'(word), 64'(WC));
      if (k == 17) check("rot_a_again", 64'(word), 64'(WA));
    end

    // Single valid source never rotates or blanks.
    src_valid = 4'b0001;
    for (int k = 0; k < 30; k++) tick("single");
    check("single_word", 64'(word), 64'(WA));

    // Alert preempting source 2 at dwell count 3.
    src_valid = 4'b0101;
    wait_for(2, 3, "pre_alert");
    a0 = acks;
    alert_req = 1'b1;
    alert_word = 32'h5EED_F00D;
    tick("alert_acc");
    alert_req = 1'b0;
    alert_word = '0;
    check("alert_shown", 64'(word), 64'(32'h5EED_F00D));
    for (int k = 0; k < 16; k++) tick("alert_run");
    check("alert_ack_once", 64'(acks - a0), 64'(1));

    // Source drop with nothing else valid falls to IDLE.
    src_valid = 4'b0100;
    wait_for(2, 4, "pre_drop");
    src_valid = 4'b0000;
    tick("drop");
    check("drop_idle_word", 64'(word), 64'(0));
    src_valid = 4'b0100;
    tick("reassert");
    check("reassert_word", 64'(word), 64'(WC));

    // Adjacent sources: direct switch, or a blank gap when enabled.
    src_valid = 4'b0011;
    for (int k = 0; k < 30; k++) tick("pair");

    // Reset during an alert discards it.
    src_valid = 4'b0101;
    alert_req = 1'b1;
    alert_word = 32'hDEAD_BEEF;
    tick("rst_alert_acc");
    alert_req = 1'b0;
    for (int k = 0; k < 3; k++) tick("rst_alert_run");
    rst_n = 1'b0;
    tick("rst_mid_alert");
    check("rst_mid_word", 64'(word), 64'(0));
    check("rst_mid_alert_flag", 64'(alert_active), 64'(0));
    rst_n = 1'b1;
    src_valid = 4'b0000;
    tick("post_rst");
    check("post_rst_word", 64'(word), 64'(0));

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int s = 0; s < NUM_SRC; s++) src_word[s*W +: W] = $urandom;
      if ($urandom_range(0, 15) == 0) src_valid = 4'($urandom);
      alert_req  = ($urandom_range(0, 39) == 0);
      alert_word = $urandom;
      rst_n      = ($urandom_range(0, 299) != 0);
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
